// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: configurable frame format, majority-vote bit decisions,
// parity/framing/break/overrun detection and a one-word valid/ready holding register.
module uart_rx_ext #(
    parameter int CLOCK_HZ   = 160,
    parameter int BAUD_RATE  = 10,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 out_break,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int DIV   = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_S = (DIV < 1) ? 1 : DIV;
    localparam int TW    = (DIV_S > 1) ? $clog2(DIV_S) : 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam int IW    = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SC_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SC_DEC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV_S - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_ext: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_ext: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_ext: CLOCK_HZ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_os
        $error("uart_rx_ext: OVERSAMPLE must be even and at least 8");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRKWAIT
    } state_t;

    state_t r_state, w_next;

    logic r_sync1, r_sync2, r_rxs_d;
    logic w_rxs;
    logic [TW-1:0] r_tick;
    logic [SW-1:0] r_sc;
    logic w_tick, w_dec_pt;
    logic r_sa, r_sb, w_bit;

    logic [DATA_BITS-1:0] r_data;
    logic [IW-1:0]        r_idx;
    logic                 r_stop_idx;
    logic                 r_ferr, r_perr, r_zero;
    logic                 w_par_exp, w_last_data, w_last_stop;

    logic w_fall, w_dec, w_complete, w_ferr_fin, w_brk_fin;
    logic w_drop, w_load;

    logic                 r_valid, r_out_perr, r_out_ferr, r_out_brk, r_overrun;
    logic [DATA_BITS-1:0] r_out_data;

    // Two-flop synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    assign w_rxs = r_sync2;

    assign w_tick   = (r_tick == TICK_LAST);
    assign w_dec_pt = w_tick && (r_sc == SC_DEC);

    // Both the tick divider and the sample counter re-phase to the start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= '0;
            r_sc   <= '0;
        end else if (w_fall) begin
            r_tick <= '0;
            r_sc   <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + TW'(1);
            if (w_tick && r_state != S_IDLE)
                r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa <= 1'b1;
            r_sb <= 1'b1;
        end else begin
            if (w_tick && r_sc == SC_A) r_sa <= w_rxs;
            if (w_tick && r_sc == SC_B) r_sb <= w_rxs;
        end
    end

    // Third vote is the live sample taken on the decision tick itself
    assign w_bit = (r_sa & r_sb) | (r_sa & w_rxs) | (r_sb & w_rxs);

    assign w_par_exp   = (^r_data) ^ PAR_ODD;
    assign w_last_data = (r_idx == IDX_LAST);
    assign w_last_stop = (r_stop_idx == STOP_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_fall) w_next = S_START;
            S_START:   if (w_dec) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:    if (w_dec && w_last_data) w_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:     if (w_dec) w_next = S_STOP;
            S_STOP:    if (w_complete) w_next = w_brk_fin ? S_BRKWAIT : S_IDLE;
            S_BRKWAIT: if (w_rxs) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fall     = 1'b0;
        w_dec      = 1'b0;
        w_complete = 1'b0;
        w_ferr_fin = r_ferr;
        w_brk_fin  = 1'b0;
        case (r_state)
            S_IDLE:  w_fall = !w_rxs && r_rxs_d;
            S_START, S_DATA, S_PAR: w_dec = w_dec_pt;
            S_STOP: begin
                w_dec      = w_dec_pt;
                w_complete = w_dec_pt && w_last_stop;
                w_ferr_fin = r_ferr | ~w_bit;
                w_brk_fin  = r_zero & ~w_bit;
            end
            default: ;
        endcase
    end

    // Frame assembly; r_zero tracks "every bit after start was 0" for break detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_fall) begin
            r_data     <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_dec) begin
            case (r_state)
                S_DATA: begin
                    r_data <= {w_bit, r_data[DATA_BITS-1:1]};
                    r_idx  <= r_idx + IW'(1);
                    r_zero <= r_zero & ~w_bit;
                end
                S_PAR: begin
                    r_perr <= w_bit ^ w_par_exp;
                    r_zero <= r_zero & ~w_bit;
                end
                S_STOP: begin
                    r_ferr     <= r_ferr | ~w_bit;
                    r_zero     <= r_zero & ~w_bit;
                    r_stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_drop = w_complete && r_valid && !out_ready;
    assign w_load = w_complete && !w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_out_data <= '0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_out_brk  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_out_data <= r_data;
                r_out_perr <= r_perr;
                r_out_ferr <= w_ferr_fin;
                r_out_brk  <= w_brk_fin;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set
            if (w_drop)           r_overrun <= 1'b1;
            else if (overrun_clr) r_overrun <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_data       = r_out_data;
    assign out_parity_err = r_out_perr;
    assign out_frame_err  = r_out_ferr;
    assign out_break      = r_out_brk;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: 8N1 instance and a 7E2 instance, line-level frame model
// feeding per-instance expected-word queues drained by handshake monitors.
module tb_uart_rx_ext;

    localparam int BIT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, rx0, rx1, rdy0, rdy1, oclr0, oclr1;
    logic v0, pe0, fe0, br0, ov0;
    logic v1, pe1, fe1, br1, ov1;
    logic [7:0] d0;
    logic [6:0] d1;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       br;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0e, m1e;
    int n_chk = 0;
    int n_pass = 0;

    uart_rx_ext u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0),
        .out_valid(v0), .out_ready(rdy0), .out_data(d0),
        .out_parity_err(pe0), .out_frame_err(fe0), .out_break(br0),
        .overrun(ov0), .overrun_clr(oclr0)
    );

    uart_rx_ext #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1),
        .out_valid(v1), .out_ready(rdy1), .out_data(d1),
        .out_parity_err(pe1), .out_frame_err(fe1), .out_break(br1),
        .overrun(ov1), .overrun_clr(oclr1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic set_rx(input int idx, input logic v);
        if (idx == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Builds the line bit sequence, derives the expected word from it, then drives it
    task automatic send_frame(input int idx, input logic [8:0] data, input bit flip,
                              input bit bad_stop, input bit glitch, input bit deliver);
        automatic int nb = (idx == 0) ? 8 : 7;
        automatic int ns = (idx == 0) ? 1 : 2;
        bit   bits[$];
        bit   par;
        bit   all0;
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(data[i]);
        par = 1'b0;
        for (int i = 0; i < nb; i++) par ^= data[i];
        if (idx == 1) bits.push_back(par ^ flip);
        for (int s = 0; s < ns; s++) bits.push_back(!bad_stop);
        e.data = 9'd0;
        for (int i = 0; i < nb; i++) e.data[i] = bits[1+i];
        e.pe = (idx == 1) ? (bits[1+nb] != par) : 1'b0;
        e.fe = 1'b0;
        for (int s = 0; s < ns; s++) if (!bits[bits.size()-1-s]) e.fe = 1'b1;
        all0 = 1'b1;
        for (int k = 1; k < bits.size(); k++) if (bits[k]) all0 = 1'b0;
        e.br = all0;
        if (deliver) begin
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        for (int k = 0; k < bits.size(); k++)
            for (int j = 0; j < BIT; j++) begin
                @(posedge clk);
                #1 set_rx(idx, bits[k] ^ (glitch && (j == 8 + (k % 3))));
            end
        @(posedge clk);
        #1 set_rx(idx, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!reset && v0 && rdy0) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL dut0 unexpected word: got %0h, want none", d0);
            end else begin
                m0e = q0.pop_front();
                check("dut0 data", {24'd0, d0}, {23'd0, m0e.data});
                check("dut0 parity_err", {31'd0, pe0}, {31'd0, m0e.pe});
                check("dut0 frame_err", {31'd0, fe0}, {31'd0, m0e.fe});
                check("dut0 break", {31'd0, br0}, {31'd0, m0e.br});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v1 && rdy1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL dut1 unexpected word: got %0h, want none", d1);
            end else begin
                m1e = q1.pop_front();
                check("dut1 data", {25'd0, d1}, {23'd0, m1e.data});
                check("dut1 parity_err", {31'd0, pe1}, {31'd0, m1e.pe});
                check("dut1 frame_err", {31'd0, fe1}, {31'd0, m1e.fe});
                check("dut1 break", {31'd0, br1}, {31'd0, m1e.br});
            end
        end
    end

    initial begin
        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; oclr0 = 1'b0; oclr1 = 1'b0;
        idle(4);
        #1;
        check("reset valid", {31'd0, v0}, 32'd0);
        check("reset data", {24'd0, d0}, 32'd0);
        check("reset flags", {29'd0, pe0, fe0, br0}, 32'd0);
        check("reset overrun", {31'd0, ov0}, 32'd0);
        reset = 1'b0;
        idle(2 * BIT);

        send_frame(0, 9'hA5, 0, 0, 0, 1);
        idle(20);
        send_frame(1, 9'h35, 0, 0, 0, 1);
        send_frame(1, 9'h35, 1, 0, 0, 1);
        send_frame(0, 9'h3C, 0, 1, 0, 1);
        idle(2 * BIT);

        // Long low line: a single break word, then nothing until the line rises
        q0.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b1, br: 1'b1});
        @(posedge clk); #1 rx0 = 1'b0;
        idle(20 * BIT);
        check("break words", q0.size(), 32'd0);
        @(posedge clk); #1 rx0 = 1'b1;
        idle(2 * BIT);

        @(posedge clk); #1 rx0 = 1'b0;
        idle(4);
        #1 rx0 = 1'b1;
        idle(3 * BIT);
        send_frame(0, 9'h55, 0, 0, 1, 1);
        idle(10);

        for (int n = 0; n < 16; n++) begin
            send_frame(0, 9'($urandom_range(0, 255)), 0, ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 1), 1);
            idle($urandom_range(0, 24));
        end
        idle(2 * BIT);

        // Overrun: held word survives a dropped frame
        rdy0 = 1'b0;
        send_frame(0, 9'h11, 0, 0, 0, (q0.size() == 0) || rdy0);
        idle(8);
        send_frame(0, 9'h22, 0, 0, 0, (q0.size() == 0) || rdy0);
        idle(8);
        check("overrun set", {31'd0, ov0}, 32'd1);
        check("held valid", {31'd0, v0}, 32'd1);
        check("held data", {24'd0, d0}, 32'h11);
        @(posedge clk); #1 oclr0 = 1'b1;
        @(posedge clk); #1 oclr0 = 1'b0;
        check("overrun cleared", {31'd0, ov0}, 32'd0);
        idle(8);

        // Accept the held word in exactly the cycle the next frame completes
        fork
            send_frame(0, 9'h33, 0, 0, 0, 1);
            begin
                repeat (157) @(posedge clk);
                #1;
                check("pre-collision data", {24'd0, d0}, 32'h11);
                rdy0 = 1'b1;
                @(posedge clk);
                #1 rdy0 = 1'b0;
                check("collision valid", {31'd0, v0}, 32'd1);
                check("collision data", {24'd0, d0}, 32'h33);
                check("collision overrun", {31'd0, ov0}, 32'd0);
            end
        join
        idle(4);
        rdy0 = 1'b1;
        idle(8);

        // Reset mid-frame with a held word and overrun pending
        rdy0 = 1'b0;
        send_frame(0, 9'h5A, 0, 0, 0, (q0.size() == 0) || rdy0);
        send_frame(0, 9'h6B, 0, 0, 0, (q0.size() == 0) || rdy0);
        check("pre-reset overrun", {31'd0, ov0}, 32'd1);
        begin
            automatic logic [8:0] pbits = {8'hC3, 1'b0};
            for (int k = 0; k < 5; k++)
                for (int j = 0; j < BIT; j++) begin
                    @(posedge clk);
                    #1 rx0 = pbits[k];
                end
        end
        @(posedge clk); #1 reset = 1'b1; rx0 = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q0.delete();
        q1.delete();
        check("midreset valid", {31'd0, v0}, 32'd0);
        check("midreset data", {24'd0, d0}, 32'd0);
        check("midreset flags", {29'd0, pe0, fe0, br0}, 32'd0);
        check("midreset overrun", {31'd0, ov0}, 32'd0);
        rdy0 = 1'b1;
        idle(3 * BIT);
        send_frame(0, 9'h81, 0, 0, 0, 1);
        idle(10);

        send_frame(1, 9'h00, 0, 1, 0, 1);
        idle(BIT);
        for (int n = 0; n < 12; n++) begin
            send_frame(1, 9'($urandom_range(0, 127)), $urandom_range(0, 1),
                       ($urandom_range(0, 5) == 0), $urandom_range(0, 1), 1);
            idle($urandom_range(0, 24));
        end

        for (int t = 0; t < 2000 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
        check("queues drained", q0.size() + q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
